aes_sub_shift: RTL
==================

Name: aes_sub_shift

Overview:
- Iterative SubBytes + ShiftRows stage of the AES-128 round datapath.
- Sits directly upstream of the MixColumns combinational stage and drives its 128-bit input from a registered output.
- Accepts one 128-bit state per transaction over valid/ready and substitutes LANES bytes per cycle through forward S-box instances.
- Applies ShiftRows and holds the result until the consumer accepts it.

Parameters:
- LANES, 4, bytes substituted per cycle. Legal values: 1, 2, 4, 8, 16. N = 16/LANES substitution cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  upstream state valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_data  in  128  input state, column-major: [127:120]=r0c0, [119:112]=r1c0, [111:104]=r2c0, [103:96]=r3c0, [95:88]=r0c1, ... [7:0]=r3c3.
- out_valid  out  1  out_data holds a finished state.
- out_ready  in  1  downstream accepts.
- out_data  out  128  ShiftRows(SubBytes(in_data)), same byte layout; feeds MixColumns.
- busy  out  1  high in SUB or HOLD.

Behaviour:
- Reset (sync, active-high): state=IDLE, out_valid=0, out_data=0, busy=0, group counter=0, work register=0.
- in_ready is combinational: (state==IDLE). Reset dominates all other events in the same cycle.
- Byte index k=0..15 maps to in_data[127-8k -: 8]; byte k is row k%4, column k/4.
- IDLE:
  - On in_valid && in_ready, load work register with in_data, clear counter, go to SUB.
  - Without in_valid, stay in IDLE.
- SUB:
  - Each cycle, replace bytes [cnt*LANES .. cnt*LANES+LANES-1] of the work register with Sbox(byte), using the FIPS-197 forward S-box table.
  - Increment cnt.
  - On the cycle cnt==N-1, also register out_data = ShiftRows(fully substituted state), set out_valid=1, and go to HOLD.
  - ShiftRows: out(r,c) = sub(r,(c+r) mod 4).
  - in_valid is ignored in SUB.
- Latency: out_valid rises exactly N clock edges after the accepting edge (LANES=4 gives 4 cycles).
- HOLD:
  - out_data and out_valid stay stable until out_ready.
  - On out_valid && out_ready, clear out_valid and go to IDLE. out_data keeps its last value.
  - No new input is accepted in the handshake cycle.
  - Maximum throughput is one block per N+2 cycles.
- out_ready is don't-care outside HOLD.
- in_data changes after acceptance must not affect the result.
- Reset asserted during SUB or HOLD: the block returns to IDLE next edge, the in-flight block is discarded, and out_valid=0.
- Counter width is clog2(N), minimum 1 bit; it does not wrap past N-1.

Optional Feature:
- Macro AES_SUB_SHIFT_CNT_EN.
- When defined:
  - Extra output blk_count [31:0] counts completed output handshakes (out_valid && out_ready).
  - It resets to 0 on rst and wraps from 32'hFFFFFFFF to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- FIPS-197 App. B round 1, LANES=4:
  - in_data=193de3bea0f4e22b9ac68d2ae9f84808 -> out_data=d4bf5d30e0b452aeb84111f11e2798e5.
  - out_valid is high exactly 4 edges after acceptance.
- Byte-order check: in_data=000102030405060708090a0b0c0d0e0f -> out_data=636b6776f201ab7b30d777c5fe7c6f2b.
- Backpressure: out_ready=0 for 10 cycles -> out_valid and out_data stable, in_ready=0 throughout. Raising out_ready -> one handshake, then in_ready=1 on the next cycle.
- Reset mid-SUB:
  - Assert rst 2 cycles after acceptance -> next cycle state IDLE, out_valid=0, busy=0, out_data=0.
  - A following block of all zeros -> out_data=63636363636363636363636363636363.
- Parameter sweep LANES=1, 2, 8, 16: App. B vector gives an identical result with latency 16, 8, 2, 1. Back-to-back in_valid gives accept spacing of N+2 cycles.
- With AES_SUB_SHIFT_CNT_EN: 3 blocks through -> blk_count=3. After rst -> blk_count=0.

Source files
------------

// File: rtl/aes_sub_shift.sv
// Iterative AES SubBytes+ShiftRows: LANES S-boxes per cycle, result registered after 16/LANES cycles and held until out_ready.
// Optional AES_SUB_SHIFT_CNT_EN adds blk_count, a wrapping count of completed output handshakes.
module aes_sub_shift #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
`ifdef AES_SUB_SHIFT_CNT_EN
    ,
    output logic [31:0]  blk_count
`endif
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_HOLD
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [127:0]   r_work;
    logic [127:0]   r_out_data;
    logic           r_out_valid;
    logic [127:0]   w_work_sub;
    logic [127:0]   w_shifted;
    logic           w_accept;
    logic           w_last;
    logic           w_done;
    logic [3:0]     w_lane_idx [LANES];
    logic [7:0]     w_lane_in  [LANES];
    logic [7:0]     w_lane_out [LANES];

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_state == S_SUB) && (r_cnt == LAST);
    assign w_done   = r_out_valid && out_ready;

    // Each lane picks the byte of the current group, so only LANES S-boxes exist.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_lane_idx[l] = 4'(int'(r_cnt) * LANES + l);
        assign w_lane_in[l]  = r_work[127 - 8*w_lane_idx[l] -: 8];
        assign w_lane_out[l] = sbox(w_lane_in[l]);
    end

    always_comb begin
        w_work_sub = r_work;
        for (int l = 0; l < LANES; l++) begin
            w_work_sub[127 - 8*w_lane_idx[l] -: 8] = w_lane_out[l];
        end
    end

    // Row r of the output is row r of the substituted state rotated left by r columns.
    always_comb begin
        w_shifted = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                w_shifted[127 - 8*(4*c + r) -: 8] = w_work_sub[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_SUB;
            S_SUB:   if (w_last)   w_state_nxt = S_HOLD;
            S_HOLD:  if (w_done)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_work      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_work <= in_data;
                        r_cnt  <= '0;
                    end
                end
                S_SUB: begin
                    r_work <= w_work_sub;
                    if (w_last) begin
                        r_out_data  <= w_shifted;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (w_done) r_out_valid <= 1'b0;
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

`ifdef AES_SUB_SHIFT_CNT_EN
    logic [31:0] r_blk_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_count <= '0;
        end else if (w_done) begin
            r_blk_count <= r_blk_count + 32'd1;
        end
    end

    assign blk_count = r_blk_count;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
